// File: rtl/sram_fifo_ctrl.sv
// Show-ahead valid/ready FIFO controller wrapping a 1r1w OpenRAM macro (clk0 = clk1 = clk).
// Optional peak-level watermark (max_level_out, wm_clear_in) under `SRAM_FIFO_CTRL_WATERMARK_EN.
`timescale 1ns/1ps
module sram_fifo_ctrl #(
   parameter int DATA_WIDTH   = 8,
   parameter int ADDR_WIDTH   = 10,
   parameter int AFULL_THRESH = 1020
) (
   input  logic                  clk,
   input  logic                  arst_n_in,
   input  logic                  flush_in,
   input  logic                  wr_valid_in,
   output logic                  wr_ready_out,
   input  logic [DATA_WIDTH-1:0] wr_data_in,
   output logic                  rd_valid_out,
   input  logic                  rd_ready_in,
   output logic [DATA_WIDTH-1:0] rd_data_out,
   output logic [ADDR_WIDTH+1:0] level_out,
   output logic                  almost_full_out,
`ifdef SRAM_FIFO_CTRL_WATERMARK_EN
   input  logic                  wm_clear_in,
   output logic [ADDR_WIDTH+1:0] max_level_out,
`endif
   output logic                  sram_csb0_out,
   output logic [ADDR_WIDTH-1:0] sram_addr0_out,
   output logic [DATA_WIDTH-1:0] sram_din0_out,
   output logic                  sram_csb1_out,
   output logic [ADDR_WIDTH-1:0] sram_addr1_out,
   input  logic [DATA_WIDTH-1:0] sram_dout1_in
);

   logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr, addr0_q;
   logic [DATA_WIDTH-1:0] din0_q, obuf_tail;
   logic [ADDR_WIDTH:0]   sram_cnt;
   logic                  rd_pend;
   logic [1:0]            obuf_cnt;
   logic [ADDR_WIDTH+1:0] level_nxt;
   logic [2:0]            occ;
   logic                  wr_acc, pop, issue;

   always_comb begin
      wr_ready_out   = !sram_cnt[ADDR_WIDTH] && !flush_in;
      wr_acc         = wr_valid_in && wr_ready_out;
      rd_valid_out   = (obuf_cnt != 2'd0);
      pop            = rd_valid_out && rd_ready_in && !flush_in;
      occ            = {1'b0, obuf_cnt} + {2'b00, rd_pend};
      // Only committed entries are read, so addr1 never equals a same-cycle addr0.
      issue          = !flush_in && (sram_cnt != '0) &&
                       ((occ < 3'd2) || (pop && (occ == 3'd2)));
      sram_csb0_out  = !wr_acc;
      sram_addr0_out = wr_acc ? wr_ptr : addr0_q;
      sram_din0_out  = wr_acc ? wr_data_in : din0_q;
      sram_csb1_out  = !issue;
      sram_addr1_out = rd_ptr;
      level_nxt      = level_out + {{(ADDR_WIDTH+1){1'b0}}, wr_acc}
                                 - {{(ADDR_WIDTH+1){1'b0}}, pop};
   end

   always_ff @(posedge clk or negedge arst_n_in) begin
      if (!arst_n_in) begin
         wr_ptr          <= '0;
         rd_ptr          <= '0;
         addr0_q         <= '0;
         din0_q          <= '0;
         sram_cnt        <= '0;
         rd_pend         <= 1'b0;
         level_out       <= '0;
         almost_full_out <= 1'b0;
      end else if (flush_in) begin
         wr_ptr          <= '0;
         rd_ptr          <= '0;
         sram_cnt        <= '0;
         rd_pend         <= 1'b0;
         level_out       <= '0;
         almost_full_out <= 1'b0;
      end else begin
         if (wr_acc) begin
            wr_ptr  <= wr_ptr + 1'b1;
            addr0_q <= wr_ptr;
            din0_q  <= wr_data_in;
         end
         if (issue)
            rd_ptr <= rd_ptr + 1'b1;
         case ({wr_acc, issue})
            2'b10:   sram_cnt <= sram_cnt + 1'b1;
            2'b01:   sram_cnt <= sram_cnt - 1'b1;
            default: sram_cnt <= sram_cnt;
         endcase
         rd_pend         <= issue;
         level_out       <= level_nxt;
         almost_full_out <= (level_nxt >= (ADDR_WIDTH+2)'(AFULL_THRESH));
      end
   end

   // rd_data_out is the head slot; obuf_tail holds the second entry.
   always_ff @(posedge clk or negedge arst_n_in) begin
      if (!arst_n_in) begin
         obuf_cnt    <= 2'd0;
         rd_data_out <= '0;
         obuf_tail   <= '0;
      end else if (flush_in) begin
         obuf_cnt    <= 2'd0;
         rd_data_out <= '0;
      end else begin
         case ({rd_pend, pop})
            2'b10: begin
               if (obuf_cnt == 2'd0) rd_data_out <= sram_dout1_in;
               else                  obuf_tail   <= sram_dout1_in;
               obuf_cnt <= obuf_cnt + 1'b1;
            end
            2'b01: begin
               rd_data_out <= obuf_tail;
               obuf_cnt    <= obuf_cnt - 1'b1;
            end
            2'b11: begin
               if (obuf_cnt == 2'd1) begin
                  rd_data_out <= sram_dout1_in;
               end else begin
                  rd_data_out <= obuf_tail;
                  obuf_tail   <= sram_dout1_in;
               end
            end
            default: obuf_cnt <= obuf_cnt;
         endcase
      end
   end

`ifdef SRAM_FIFO_CTRL_WATERMARK_EN
   always_ff @(posedge clk or negedge arst_n_in) begin
      if (!arst_n_in)
         max_level_out <= '0;
      else if (flush_in)
         max_level_out <= '0;
      else if (wm_clear_in)
         max_level_out <= level_out;
      else if (level_out > max_level_out)
         max_level_out <= level_out;
   end
`endif

endmodule

// File: doc/sram_fifo_ctrl.md
Name: sram_fifo_ctrl

Overview:
Single-clock FIFO controller that drives one 1r1w OpenRAM SRAM macro as a show-ahead FIFO with valid/ready on both sides.
- Owns the write/read pointers and the occupancy count.
- Absorbs the macro's 1-cycle registered read latency with a 2-entry output buffer.
- Keeps a read from ever hitting an address that is being written in the same cycle.
- Sits between accelerator producer/consumer stages and the SRAM FIFO macro, with clk0 = clk1 = clk.

Parameters:
DATA_WIDTH, 8, word width; must match the macro.
ADDR_WIDTH, 10, macro address width; DEPTH = 1<<ADDR_WIDTH.
AFULL_THRESH, 1020, almost_full_out asserts when level_out >= AFULL_THRESH.

Ports:
clk  in  1  clock; also drives macro clk0/clk1.
arst_n_in  in  1  asynchronous active-low reset.
flush_in  in  1  synchronous clear of all contents.
wr_valid_in  in  1  producer has data.
wr_ready_out  out  1  controller accepts the write this cycle.
wr_data_in  in  DATA_WIDTH  write data.
rd_valid_out  out  1  rd_data_out is valid.
rd_ready_in  in  1  consumer takes data.
rd_data_out  out  DATA_WIDTH  head of FIFO, registered.
level_out  out  ADDR_WIDTH+2  total entries held (SRAM + in-flight + output buffer).
almost_full_out  out  1  level_out >= AFULL_THRESH.
sram_csb0_out  out  1  macro write chip select, active low.
sram_addr0_out  out  ADDR_WIDTH  macro write address.
sram_din0_out  out  DATA_WIDTH  macro write data.
sram_csb1_out  out  1  macro read chip select, active low.
sram_addr1_out  out  ADDR_WIDTH  macro read address.
sram_dout1_in  in  DATA_WIDTH  macro read data.

Behaviour:
- Reset (arst_n_in=0, async):
  - wr_ptr = rd_ptr = 0; sram_cnt = 0; rd_pend = 0; obuf empty.
  - rd_valid_out = 0, rd_data_out = 0, level_out = 0, almost_full_out = 0.
  - sram_csb0_out = sram_csb1_out = 1.
  - wr_ready_out = 1 once reset is released.
- Write:
  - wr_ready_out = (sram_cnt < DEPTH) && !flush_in.
  - On accept (valid && ready): in the same cycle, combinationally drive csb0 = 0, addr0 = wr_ptr, din0 = wr_data_in.
  - At the clock edge: wr_ptr += 1 (natural wrap at DEPTH) and sram_cnt += 1.
  - Otherwise csb0 = 1; addr0/din0 hold their last values.
- Read issue:
  - Issue when sram_cnt > 0 and (obuf_cnt + rd_pend − pop) < 2, where pop = rd_valid_out && rd_ready_in.
  - On issue: csb1 = 0, addr1 = rd_ptr; at the edge, rd_ptr += 1, sram_cnt −= 1, rd_pend = 1.
  - Otherwise csb1 = 1.
- Capture: when rd_pend = 1, sram_dout1_in is sampled at the next rising edge into obuf, before the macro's hold-time X.
  - sram_cnt increments and decrements in the same cycle cancel.
- Collision: a read is issued only against entries committed in an earlier cycle. Read and write addresses in the same cycle are therefore never equal; the bench asserts this.
- Output buffer:
  - 2-entry FIFO; its head drives rd_data_out and rd_valid_out = (obuf_cnt > 0).
  - Simultaneous pop and capture is legal and keeps ordering.
  - rd_data_out stays stable while rd_valid_out && !rd_ready_in.
- Latency: write accepted in cycle 0 to an empty FIFO → read issued cycle 1 → dout1 captured at end of cycle 2 → rd_valid_out = 1 in cycle 3.
- Throughput: sustained 1 word/cycle when rd_ready_in is held high.
- level_out = sram_cnt + rd_pend + obuf_cnt, registered; maximum value DEPTH + 2.
  - Full condition for writes is sram_cnt == DEPTH only.
- Flush (sync, highest priority):
  - Next cycle matches the reset state.
  - An in-flight read is discarded.
  - Writes and pops in the flush cycle are ignored (wr_ready_out = 0).
- Reset mid-operation: all state clears immediately. The macro contents are don't-care.

Optional Feature:
SRAM_FIFO_CTRL_WATERMARK_EN:
- Defined:
  - Adds output port max_level_out (ADDR_WIDTH+2), the peak level_out since reset or flush.
  - Adds input port wm_clear_in, a sync pulse that loads max_level_out with the current level_out.
  - Updates the cycle after level_out changes.
- Undefined: the ports and logic are absent.

Test Plan:
- Reset then idle 10 cycles → wr_ready_out = 1, rd_valid_out = 0, level_out = 0, csb0 = csb1 = 1 throughout.
- Write 0xA5 in cycle 0, rd_ready_in = 1 → rd_valid_out rises in cycle 3 with rd_data_out = 0xA5; level_out goes 1 → 0 after the pop.
- Write 1026 words 0..1025 (mod 256) with rd_ready_in = 0:
  - Expect 1024 to land in SRAM and 2 in obuf.
  - Expect wr_ready_out = 0 with level_out = 1026, and almost_full_out = 1 from level 1020.
  - Drain all → in-order data, no X on rd_data_out.
- Continuous write and read for 3000 words with random rd_ready_in and wr_valid_in → scoreboard matches, pointers wrap cleanly, no same-address read/write in any cycle.
- flush_in pulsed with 5 SRAM entries and a read in flight → next cycle level_out = 0, rd_valid_out = 0; a subsequent write of 0x3C is read back as 0x3C.
- With SRAM_FIFO_CTRL_WATERMARK_EN: fill to 40, drain to 0 → max_level_out = 40; pulse wm_clear_in → max_level_out = 0.
